// File: rtl/axi_empty_slave_pkg.sv
// Shared AXI constants for the empty-slave codebase slice: response encodings
// and burst-length width.
package axi_empty_slave_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int AXI_LEN_WIDTH = 8;

  localparam logic [AXI_LEN_WIDTH-1:0] AXI_LEN_ZERO = 8'd0;
  localparam logic [AXI_LEN_WIDTH-1:0] AXI_LEN_ONE  = 8'd1;

endpackage

// File: rtl/axi_empty_slave_beat.sv
// Burst beat counter: loads LEN on the address handshake, counts down on each
// data handshake and flags the final beat.
module axi_beat_counter
  import axi_empty_slave_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_load,
  input  logic [AXI_LEN_WIDTH-1:0] i_len,
  input  logic                     i_dec,
  output logic                     o_zero,
  output logic                     o_next_zero
);

  logic [AXI_LEN_WIDTH-1:0] r_count;
  logic [AXI_LEN_WIDTH-1:0] w_next_count;

  // Next count: a load wins over a decrement; zero is a floor, never wrapped.
  always_comb begin
    w_next_count = r_count;
    if (i_load) begin
      w_next_count = i_len;
    end else if (i_dec && (r_count != AXI_LEN_ZERO)) begin
      w_next_count = r_count - AXI_LEN_ONE;
    end else begin
      w_next_count = r_count;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= AXI_LEN_ZERO;
    end else begin
      r_count <= w_next_count;
    end
  end

  assign o_zero      = (r_count == AXI_LEN_ZERO);
  assign o_next_zero = (w_next_count == AXI_LEN_ZERO);

endmodule

// File: rtl/axi_empty_slave.sv
// AXI4 empty slave: accepts every burst, consumes all W beats, returns ARLEN+1
// R beats and a fixed error response tagged with the originating ID.
module axi_empty_slave #(
  parameter int         C_AXI_ID_WIDTH   = 2,
  parameter int         C_AXI_DATA_WIDTH = 32,
  parameter logic [1:0] OPT_RESP         = axi_empty_slave_pkg::AXI_RESP_DECERR
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          i_reset,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  output logic [C_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [7:0]                    S_AXI_ARLEN,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [C_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  wstate_t                   r_wstate;
  rstate_t                   r_rstate;
  logic                      r_awready;
  logic                      r_wready;
  logic                      r_bvalid;
  logic [C_AXI_ID_WIDTH-1:0] r_bid;
  logic                      r_arready;
  logic                      r_rvalid;
  logic                      r_rlast;
  logic [C_AXI_ID_WIDTH-1:0] r_rid;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_wcount_zero;
  logic w_wcount_next_zero;
  logic w_rcount_zero;
  logic w_rcount_next_zero;
  logic w_unused;

  assign w_aw_hs = S_AXI_AWVALID && r_awready;
  assign w_w_hs  = S_AXI_WVALID  && r_wready;
  assign w_ar_hs = S_AXI_ARVALID && r_arready;
  assign w_r_hs  = r_rvalid      && S_AXI_RREADY;

  axi_beat_counter u_wcount (
    .i_clk       (S_AXI_ACLK),
    .i_reset     (i_reset),
    .i_load      (w_aw_hs),
    .i_len       (S_AXI_AWLEN),
    .i_dec       (w_w_hs),
    .o_zero      (w_wcount_zero),
    .o_next_zero (w_wcount_next_zero)
  );

  axi_beat_counter u_rcount (
    .i_clk       (S_AXI_ACLK),
    .i_reset     (i_reset),
    .i_load      (w_ar_hs),
    .i_len       (S_AXI_ARLEN),
    .i_dec       (w_r_hs),
    .o_zero      (w_rcount_zero),
    .o_next_zero (w_rcount_next_zero)
  );

  // Write data contents and WLAST never matter; burst end comes from AWLEN.
  always_ff @(posedge S_AXI_ACLK) begin
    if (i_reset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= {C_AXI_ID_WIDTH{1'b0}};
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_wstate  <= W_DATA;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_bid     <= S_AXI_AWID;
          end else begin
            r_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_w_hs && w_wcount_zero) begin
            r_wstate <= W_RESP;
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
          end
        end
        default: begin
          r_wstate  <= W_IDLE;
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (i_reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= {C_AXI_ID_WIDTH{1'b0}};
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rstate  <= R_DATA;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rlast   <= w_rcount_next_zero;
            r_rid     <= S_AXI_ARID;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            if (w_rcount_zero) begin
              r_rstate  <= R_IDLE;
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
            end else begin
              r_rlast <= w_rcount_next_zero;
            end
          end
        end
        default: begin
          r_rstate  <= R_IDLE;
          r_arready <= 1'b0;
          r_rvalid  <= 1'b0;
          r_rlast   <= 1'b0;
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BID     = r_bid;
  assign S_AXI_BRESP   = OPT_RESP;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RID     = r_rid;
  assign S_AXI_RDATA   = {C_AXI_DATA_WIDTH{1'b0}};
  assign S_AXI_RRESP   = OPT_RESP;
  assign S_AXI_RLAST   = r_rlast;

  assign w_unused = ^{S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, w_wcount_next_zero};

endmodule

// File: tb/tb_axi_empty_slave.sv
// Directed bench for axi_empty_slave with a B/R response scoreboard.
module tb_axi_empty_slave;

  localparam int IW = 2;
  localparam int DW = 32;

  typedef struct {
    logic [IW-1:0] id;
    logic          last;
  } rexp_t;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [IW-1:0] awid, bid, arid, rid;
  logic [7:0]    awlen, arlen;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready, rlast;

  int n_cmp = 0;
  int n_err = 0;
  int w_beats = 0;
  int b_seen = 0;
  int r_seen = 0;
  int start;

  logic [IW-1:0] bq[$];
  rexp_t         rq[$];
  rexp_t         r_e;
  logic [IW-1:0] b_e;
  logic          stall_prev = 1'b0;
  logic [IW-1:0] stall_id;
  logic          stall_last;

  always #5 clk = ~clk;

  axi_empty_slave #(
    .C_AXI_ID_WIDTH  (IW),
    .C_AXI_DATA_WIDTH(DW),
    .OPT_RESP        (2'b11)
  ) dut (
    .S_AXI_ACLK   (clk),
    .i_reset      (i_reset),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_AWID   (awid),
    .S_AXI_AWLEN  (awlen),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WLAST  (wlast),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_BID    (bid),
    .S_AXI_BRESP  (bresp),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_ARID   (arid),
    .S_AXI_ARLEN  (arlen),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .S_AXI_RID    (rid),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RLAST  (rlast)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops expected responses at each handshake, checks stalls.
  always @(negedge clk) begin
    if (i_reset) begin
      stall_prev <= 1'b0;
    end else begin
      if (wvalid && wready) w_beats <= w_beats + 1;
      if (bvalid && bready) begin
        b_seen <= b_seen + 1;
        check("b_pending", 64'(bq.size() > 0), 64'd1);
        if (bq.size() > 0) begin
          b_e = bq.pop_front();
          check("bid", 64'(bid), 64'(b_e));
        end
        check("bresp", 64'(bresp), 64'd3);
      end
      if (rvalid && rready) begin
        r_seen <= r_seen + 1;
        check("r_pending", 64'(rq.size() > 0), 64'd1);
        if (rq.size() > 0) begin
          r_e = rq.pop_front();
          check("rid", 64'(rid), 64'(r_e.id));
          check("rlast", 64'(rlast), 64'(r_e.last));
        end
        check("rdata", 64'(rdata), 64'd0);
        check("rresp", 64'(rresp), 64'd3);
      end
      if (stall_prev) begin
        check("stall_rvalid", 64'(rvalid), 64'd1);
        check("stall_rid", 64'(rid), 64'(stall_id));
        check("stall_rlast", 64'(rlast), 64'(stall_last));
      end
      stall_prev <= rvalid && !rready;
      stall_id   <= rid;
      stall_last <= rlast;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_r(input logic [IW-1:0] id, input int len);
    rexp_t e;
    for (int i = 0; i <= len; i++) begin
      e.id   = id;
      e.last = (i == len);
      rq.push_back(e);
    end
  endtask

  initial begin
    i_reset = 1'b1;
    awvalid = 1'b0; awid = '0; awlen = 8'd0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
    arvalid = 1'b0; arid = '0; arlen = 8'd0; rready = 1'b0;
    cyc(); cyc(); cyc();
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    i_reset = 1'b0;
    cyc();
    check("post_rst_awready", 64'(awready), 64'd1);
    check("post_rst_arready", 64'(arready), 64'd1);

    // Single-beat write.
    start = w_beats;
    awid = 2'd2; awlen = 8'd0; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    bq.push_back(2'd2);
    cyc();
    awvalid = 1'b0;
    check("w1_awready_t1", 64'(awready), 64'd0);
    check("w1_wready_t1", 64'(wready), 64'd1);
    cyc();
    wvalid = 1'b0;
    check("w1_bvalid_t2", 64'(bvalid), 64'd1);
    check("w1_bid_t2", 64'(bid), 64'd2);
    cyc();
    check("w1_bvalid_t3", 64'(bvalid), 64'd0);
    check("w1_awready_t3", 64'(awready), 64'd1);
    check("w1_beats", 64'(w_beats - start), 64'd1);

    // Four-beat read, RREADY held high.
    arid = 2'd1; arlen = 8'd3; arvalid = 1'b1; rready = 1'b1;
    push_r(2'd1, 3);
    cyc();
    arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("r4_rvalid", 64'(rvalid), 64'd1);
      check("r4_rlast", 64'(rlast), 64'(i == 3));
      check("r4_arready", 64'(arready), 64'd0);
      cyc();
    end
    check("r4_rvalid_t5", 64'(rvalid), 64'd0);
    check("r4_arready_t5", 64'(arready), 64'd1);

    // 256-beat read with RREADY toggling.
    start = r_seen;
    arid = 2'd3; arlen = 8'd255; arvalid = 1'b1;
    push_r(2'd3, 255);
    cyc();
    arvalid = 1'b0;
    for (int k = 0; (k < 1000) && ((r_seen - start) < 256); k++) begin
      rready = (k % 2 == 0);
      cyc();
    end
    rready = 1'b1;
    check("r256_beats", 64'(r_seen - start), 64'd256);
    check("r256_rvalid_done", 64'(rvalid), 64'd0);
    check("r256_arready_done", 64'(arready), 64'd1);

    // Four-beat write, WLAST early on beat 2.
    start = w_beats;
    awid = 2'd1; awlen = 8'd3; awvalid = 1'b1;
    bq.push_back(2'd1);
    cyc();
    awvalid = 1'b0; wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wlast = (i == 1);
      check("w4_wready", 64'(wready), 64'd1);
      check("w4_bvalid_early", 64'(bvalid), 64'd0);
      cyc();
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("w4_bvalid", 64'(bvalid), 64'd1);
    check("w4_beats", 64'(w_beats - start), 64'd4);
    check("w4_wready_after", 64'(wready), 64'd0);
    cyc();
    check("w4_bvalid_after", 64'(bvalid), 64'd0);

    // Concurrent AW and AR, BREADY held low.
    start = b_seen;
    awid = 2'd3; awlen = 8'd1; awvalid = 1'b1;
    arid = 2'd2; arlen = 8'd1; arvalid = 1'b1;
    wvalid = 1'b1; bready = 1'b0; rready = 1'b1;
    bq.push_back(2'd3);
    push_r(2'd2, 1);
    cyc();
    awvalid = 1'b0; arvalid = 1'b0;
    cyc(); cyc();
    wvalid = 1'b0;
    check("cc_rvalid_done", 64'(rvalid), 64'd0);
    check("cc_arready", 64'(arready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("cc_bvalid_hold", 64'(bvalid), 64'd1);
      check("cc_bid_hold", 64'(bid), 64'd3);
      cyc();
    end
    bready = 1'b1;
    cyc();
    check("cc_bvalid_after", 64'(bvalid), 64'd0);
    check("cc_awready_after", 64'(awready), 64'd1);
    check("cc_b_count", 64'(b_seen - start), 64'd1);

    // Reset mid-burst on both channels.
    awid = 2'd0; awlen = 8'd5; awvalid = 1'b1;
    arid = 2'd0; arlen = 8'd5; arvalid = 1'b1;
    rready = 1'b0; wvalid = 1'b0;
    cyc();
    awvalid = 1'b0; arvalid = 1'b0;
    cyc();
    check("mid_wready", 64'(wready), 64'd1);
    check("mid_rvalid", 64'(rvalid), 64'd1);
    i_reset = 1'b1;
    cyc();
    check("rr_awready", 64'(awready), 64'd0);
    check("rr_wready", 64'(wready), 64'd0);
    check("rr_bvalid", 64'(bvalid), 64'd0);
    check("rr_arready", 64'(arready), 64'd0);
    check("rr_rvalid", 64'(rvalid), 64'd0);
    check("rr_rlast", 64'(rlast), 64'd0);
    i_reset = 1'b0;
    rready = 1'b1;
    cyc();
    check("rr_awready_rel", 64'(awready), 64'd1);
    check("rr_arready_rel", 64'(arready), 64'd1);
    start = b_seen;
    awid = 2'd1; awlen = 8'd0; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    bq.push_back(2'd1);
    cyc();
    awvalid = 1'b0;
    cyc();
    wvalid = 1'b0;
    check("rr_fresh_bvalid", 64'(bvalid), 64'd1);
    cyc();
    check("rr_fresh_done", 64'(bvalid), 64'd0);
    check("rr_fresh_b_count", 64'(b_seen - start), 64'd1);

    check("bq_drained", 64'(bq.size()), 64'd0);
    check("rq_drained", 64'(rq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_empty_slave.md
# axi_empty_slave

Full AXI4 (burst, ID) successor to the AXI-lite empty slave: terminates every write and read burst with a fixed error response so that an interconnect port with no real slave behind it never hangs a master. Sits on an unused interconnect slave port. It honours burst lengths by consuming every W beat and producing ARLEN+1 R beats with RLAST. It returns the transaction ID on B and R, and has a parametrised ID width and response code.

## Interface
- C_AXI_ID_WIDTH, 2: width of AWID/BID/ARID/RID; minimum 1.
- C_AXI_DATA_WIDTH, 32: width of WDATA/RDATA; power of two, ≥8.
- OPT_RESP, 2'b11: constant BRESP/RRESP value (DECERR by default; 2'b10 for SLVERR).
- S_AXI_ACLK  in  1  clock; all logic on rising edge.
- i_reset  in  1  reset: synchronous, active-high. Clock is S_AXI_ACLK.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_AWID  in  C_AXI_ID_WIDTH  write ID, captured on AW handshake.
- S_AXI_AWLEN  in  8  write burst length minus one.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST  in  DW, DW/8, 1  all ignored.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_BID  out  C_AXI_ID_WIDTH  captured AWID.
- S_AXI_BRESP  out  2  constant OPT_RESP.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_ARID  in  C_AXI_ID_WIDTH  read ID, captured on AR handshake.
- S_AXI_ARLEN  in  8  read burst length minus one.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- S_AXI_RID  out  C_AXI_ID_WIDTH  captured ARID.
- S_AXI_RDATA  out  DW  constant zero.
- S_AXI_RRESP  out  2  constant OPT_RESP.
- S_AXI_RLAST  out  1  high on the final beat of the burst.

## Operation
- The write and read channels are fully independent FSMs. Each accepts one burst at a time.
- Write FSM states:
  - W_IDLE (AWREADY=1). On AW handshake: wcount←AWLEN, bid←AWID, go to W_DATA.
  - W_DATA (WREADY=1). On each W handshake: if wcount==0 go to W_RESP, else wcount−1.
  - W_RESP (BVALID=1). On BREADY go to W_IDLE.
- The write burst ends after exactly AWLEN+1 beats. WLAST is not consulted; an early or late WLAST has no effect.
- Read FSM states:
  - R_IDLE (ARREADY=1). On AR handshake: rcount←ARLEN, rid←ARID, go to R_DATA.
  - R_DATA (RVALID=1, RLAST=(rcount==0)). On RREADY: if rcount==0 go to R_IDLE, else rcount−1.
- AWREADY, WREADY, BVALID, ARREADY and RVALID are registered, decoded from next-state.
- BID/RID hold their value while VALID is high. BID/RID are don't-care while VALID is low.
- rcount and wcount are 8-bit counters. They never underflow because a state exit happens at 0.
- Reset values (i_reset high, and on the cycle it is sampled): state IDLE; AWREADY=0, WREADY=0, BVALID=0, ARREADY=0, RVALID=0, RLAST=0; counters and IDs 0.
- AWREADY and ARREADY rise on the first cycle after reset deasserts.
- Reset mid-burst abandons the burst. All VALIDs are low on the cycle after i_reset is sampled.

## Timing
- Write with all valids and BREADY held high:
  - AW handshake at t0.
  - W beats at t1…t1+AWLEN.
  - BVALID at t2+AWLEN, handshaken the same cycle.
  - AWREADY at t3+AWLEN.
  - Burst period is AWLEN+3 cycles.
- Read with RREADY held high:
  - AR handshake at t0.
  - R beats at t1…t1+ARLEN.
  - ARREADY at t2+ARLEN.
  - Burst period is ARLEN+2 cycles.
- VALID never drops without its handshake, and RLAST is stable while RVALID is stalled.
- W beats presented before AW are stalled (WREADY=0) until AW is accepted. This cannot deadlock because AWREADY is high in W_IDLE.
- Simultaneous AW and AR handshakes in the same cycle are independent and legal.

## Structure
- The AXI response encodings (OKAY=2'b00, EXOKAY, SLVERR, DECERR=2'b11) belong in the shared AXI constants package. OPT_RESP defaults from it.
- FSM state encodings are local to the module.
- No sub-module is required. The burst beat counter is natural as a shared sub-module named axi_beat_counter (load len, decrement on handshake, flag zero), instantiated once per channel.

## Test plan
- Reset, then AWID=2, AWLEN=0, one W beat, BREADY=1 -> BVALID at t2 with BID=2, BRESP=2'b11; AWREADY high at t3.
- ARID=1, ARLEN=3, RREADY=1 -> four R beats at t1–t4 with RDATA=0, RRESP=2'b11, RID=1, RLAST only at t4; ARREADY at t5.
- ARLEN=255 with RREADY toggling 1/0 -> exactly 256 beats; RLAST on beat 256 only; RVALID/RID/RLAST stable during stalls.
- AWLEN=3 with WLAST asserted on beat 2 -> still 4 W beats consumed; single B after the 4th.
- Concurrent AW (AWLEN=1) and AR (ARLEN=1) at t0 -> both complete independently with their IDs; BREADY held low 5 cycles keeps BVALID and BID stable.
- i_reset asserted during W_DATA and R_DATA -> next cycle all VALID/READY low; after release, a fresh AWLEN=0 burst completes normally.
